// File: rtl/receiver_spi.sv
// SPI slave receiver: oversampled SCK/CS/MOSI, LSB-first words in,
// response word out on MISO, all four CKP/CPH modes, streaming words.
module receiver_spi #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic s_sck;
    logic s_cs;
    logic s_mosi;
    logic sck_q;
    logic cs_q;

    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              reload;
    logic              first;

    logic lead;
    logic trail;
    logic sample_ev;
    logic shift_ev;
    logic cs_fall;
    logic word_done;

    assign s_sck  = sck_sync[SYNC_STAGES-1];
    assign s_cs   = cs_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];

    assign lead      = (sck_q == CKP) && (s_sck != CKP);
    assign trail     = (sck_q != CKP) && (s_sck == CKP);
    assign sample_ev = CPH ? trail : lead;
    assign shift_ev  = CPH ? lead : trail;
    assign cs_fall   = cs_q && !s_cs;
    assign word_done = sample_ev && (bit_cnt == LAST);
    assign rx_next   = {s_mosi, rx_shift[DATA_W-1:1]};
    assign busy      = (state == ACTIVE);

    // Bring the asynchronous pins into the clk domain
    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_q     <= s_sck;
            cs_q      <= s_cs;
        end
    end

    // Frame FSM with the shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rx_shift  <= '0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            reload    <= 1'b0;
            first     <= 1'b0;
            MISO      <= 1'b0;
            miso_oe   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            miso_oe   <= !s_cs;
            unique case (state)
                IDLE: begin
                    rx_shift <= '0;
                    bit_cnt  <= '0;
                    reload   <= 1'b0;
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        tx_shift <= tx_data;
                        MISO     <= tx_data[0];
                        first    <= 1'b1;
                    end else begin
                        tx_shift <= '0;
                        MISO     <= 1'b0;
                        first    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (sample_ev) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            reload   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    // CPH=1 leaves bit 0 on MISO for the first leading edge
                    if (shift_ev) begin
                        first <= 1'b0;
                        if (!(CPH && first)) begin
                            if (reload) begin
                                tx_shift <= tx_data;
                                MISO     <= tx_data[0];
                                reload   <= 1'b0;
                            end else begin
                                tx_shift <= tx_shift >> 1;
                                MISO     <= tx_shift[1];
                            end
                        end
                    end
                    if (s_cs) begin
                        if (bit_cnt != '0 && !word_done) begin
                            state     <= ABORT;
                            frame_err <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ABORT: begin
                    state    <= IDLE;
                    rx_shift <= '0;
                    tx_shift <= '0;
                    bit_cnt  <= '0;
                    reload   <= 1'b0;
                    first    <= 1'b0;
                    MISO     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_spi.sv
// Directed bench for receiver_spi: modes, streaming words,
// aborted frames and mid-frame reset.
module tb_receiver_spi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       CKP = 1'b0;
    logic       CPH = 1'b0;
    logic       SCK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       MISO;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;
    logic [7:0] rx_q[$];

    receiver_spi #(
        .DATA_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .CKP(CKP),
        .CPH(CPH),
        .SCK(SCK),
        .CS(CS),
        .MOSI(MOSI),
        .tx_data(tx_data),
        .MISO(MISO),
        .miso_oe(miso_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .frame_err(frame_err)
    );

    // 10 ns system clock; SCK half period is 8 clk cycles
    always #5 clk = ~clk;

    // Count pulses and log received words away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            rx_q.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic word(input logic [7:0] mo, input int nb,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (!CPH) begin
                MOSI = mo[i];
                half();
                SCK = ~CKP;
                mi[i] = MISO;
                half();
                SCK = CKP;
            end else begin
                SCK = ~CKP;
                MOSI = mo[i];
                half();
                SCK = CKP;
                mi[i] = MISO;
                half();
            end
        end
    endtask

    task automatic frame(input logic [7:0] mo, input logic [7:0] tx,
                         output logic [7:0] mi);
        tx_data = tx;
        CS = 1'b0;
        half();
        word(mo, 8, mi);
        half();
        CS = 1'b1;
        half();
        half();
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
        logic [1:0] mode;
        logic [7:0] exp_rx[3];
        logic [7:0] exp_tx[3];
        int v0;
        int f0;

        exp_rx = '{8'h01, 8'h02, 8'h03};
        exp_tx = '{8'h10, 8'h20, 8'h30};

        repeat (4) @(negedge clk);
        chk("rst_miso", MISO, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b1;
        half();

        v0 = n_valid;
        tx_data = 8'hA5;
        CS = 1'b0;
        half();
        chk("m00_busy_on", busy, 1);
        chk("m00_oe_on", miso_oe, 1);
        word(8'h3C, 8, mi);
        half();
        CS = 1'b1;
        half();
        half();
        chk("m00_rx", rx_data, 8'h3C);
        chk("m00_tx", mi, 8'hA5);
        chk("m00_nv", n_valid - v0, 1);
        chk("m00_busy_off", busy, 0);
        chk("m00_oe_off", miso_oe, 0);

        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            CKP = mode[1];
            CPH = mode[0];
            SCK = CKP;
            half();
            half();
            v0 = n_valid;
            frame(8'h81, 8'h7E, mi);
            chk($sformatf("mode%0d_rx", m), rx_data, 8'h81);
            chk($sformatf("mode%0d_tx", m), mi, 8'h7E);
            chk($sformatf("mode%0d_nv", m), n_valid - v0, 1);
        end

        CKP = 1'b0;
        CPH = 1'b0;
        SCK = 1'b0;
        half();
        half();
        rx_q.delete();
        v0 = n_valid;
        tx_data = 8'h10;
        CS = 1'b0;
        half();
        word(8'h01, 8, m0);
        tx_data = 8'h20;
        word(8'h02, 8, m1);
        tx_data = 8'h30;
        word(8'h03, 8, m2);
        half();
        CS = 1'b1;
        half();
        half();
        chk("b2b_nv", n_valid - v0, 3);
        chk("b2b_qsz", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_rx%0d", i),
                (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_rx[i]);
        end
        chk("b2b_tx0", m0, exp_tx[0]);
        chk("b2b_tx1", m1, exp_tx[1]);
        chk("b2b_tx2", m2, exp_tx[2]);

        v0 = n_valid;
        f0 = n_ferr;
        CS = 1'b0;
        half();
        word(8'hFF, 5, mi);
        half();
        CS = 1'b1;
        half();
        half();
        chk("abort_ferr", n_ferr - f0, 1);
        chk("abort_nv", n_valid - v0, 0);
        chk("abort_rx", rx_data, 8'h03);
        chk("abort_busy", busy, 0);
        v0 = n_valid;
        frame(8'h55, 8'h96, mi);
        chk("post_abort_rx", rx_data, 8'h55);
        chk("post_abort_tx", mi, 8'h96);
        chk("post_abort_nv", n_valid - v0, 1);

        v0 = n_valid;
        f0 = n_ferr;
        tx_data = 8'hE1;
        CS = 1'b0;
        half();
        word(8'hA7, 3, mi);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_rx", rx_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_miso", MISO, 0);
        chk("mrst_oe", miso_oe, 0);
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_ferr", frame_err, 0);
        rst = 1'b1;
        word(8'h5A, 8, mi);
        half();
        chk("mrst_ignored_nv", n_valid - v0, 0);
        chk("mrst_ignored_busy", busy, 0);
        chk("mrst_ignored_rx", rx_data, 0);
        CS = 1'b1;
        half();
        half();
        chk("mrst_no_ferr", n_ferr - f0, 0);
        frame(8'hC3, 8'h3C, mi);
        chk("mrst_new_rx", rx_data, 8'hC3);
        chk("mrst_new_tx", mi, 8'h3C);
        chk("mrst_new_nv", n_valid - v0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receiver_spi.md
# receiver_spi

SPI receiver (slave) block forming the far end of the team's SPI master link. It oversamples the incoming SCK, CS and MOSI lines on the system clock and shifts in one LSB-first word per frame. In the same frame it shifts out a locally supplied response word on MISO, and it presents each received word to local logic with a one-cycle valid pulse. It supports all four CKP/CPH modes and back-to-back words under a single CS assertion.

## Interface
- DATA_W, 8, word width in bits; bit counter is $clog2(DATA_W)+1 bits wide
- SYNC_STAGES, 2, flip-flop stages on each of SCK, CS, MOSI (minimum 2)
- clk  input  1  system clock; must be at least 8x the SCK frequency
- rst  input  1  reset, synchronous, active-low
- CKP  input  1  SCK idle level (0: idle low, 1: idle high); static while CS low
- CPH  input  1  0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge
- SCK  input  1  serial clock from master, asynchronous to clk
- CS  input  1  chip select, active-low, asynchronous
- MOSI  input  1  serial data from master, LSB first
- tx_data  input  DATA_W  response word; captured at frame start and at each word boundary
- MISO  output  1  serial data to master, LSB first
- miso_oe  output  1  MISO drive enable; 1 only while synchronized CS is low
- rx_data  output  DATA_W  last complete received word; held until the next complete word
- rx_valid  output  1  one-clk pulse when rx_data updates
- busy  output  1  high while in ACTIVE state
- frame_err  output  1  one-clk pulse when CS rises with a partial word (bit count 1..DATA_W-1)

## Operation
- Synchronized signals are called s_sck, s_cs, s_mosi. Previous-cycle s_sck is registered.
- Leading edge: s_sck leaves the CKP level. Trailing edge: s_sck returns to the CKP level.
- States:
  - IDLE: shift registers and bit count are held at 0.
  - ACTIVE: transfer in progress.
  - ABORT: lasts one cycle, then goes to IDLE.
- IDLE -> ACTIVE on s_cs falling:
  - tx_shift is loaded from tx_data, and MISO = tx_data[0] in the same cycle.
  - bit count is set to 0.
- Sample event (leading edge if CPH=0, trailing edge if CPH=1):
  - rx_shift <= {s_mosi, rx_shift[DATA_W-1:1]}.
  - bit count increments.
- Shift event (trailing edge if CPH=0, leading edge if CPH=1):
  - tx_shift shifts right, and MISO takes the new tx_shift[0].
  - CPH=1: the first leading edge of the frame does not shift; MISO keeps bit 0.
- Word boundary (sample event that brings bit count to DATA_W):
  - rx_data <= the completed word, and rx_valid pulses.
  - bit count returns to 0.
  - tx_shift reloads from tx_data at the next shift event instead of shifting, so back-to-back words stream without gaps.
- ACTIVE -> IDLE on s_cs rising with bit count 0: no pulse.
- ACTIVE -> ABORT on s_cs rising with bit count nonzero:
  - frame_err pulses.
  - rx_data is unchanged and rx_shift is discarded.
- SCK edges while s_cs is high are ignored.
- CKP or CPH changes while s_cs is low are unsupported. Behaviour is undefined until the next IDLE.

## Timing
- Reset values: MISO=0, miso_oe=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, state=IDLE, all synchronizers=CKP-independent 0.
- Input latency: a pin edge is visible as an s_* edge SYNC_STAGES clk cycles later.
- rx_valid is asserted SYNC_STAGES+1 cycles after the final sampling SCK pin edge, for exactly 1 cycle.
- MISO update is registered: it changes SYNC_STAGES+1 cycles after the shift-edge pin transition. The master samples no earlier than half an SCK period later, which the 8x clk ratio guarantees.
- miso_oe follows s_cs with 1 registered cycle of delay.
- Simultaneous word boundary and s_cs rising in the same cycle: rx_valid pulses, no frame_err, and the next state is IDLE.
- rst low mid-frame: all state clears on the next clk edge, and no rx_valid or frame_err is generated. After reset release, a frame already in progress (s_cs low) is ignored until s_cs rises and falls again.

## Test plan
- Mode 00, DATA_W=8, tx_data=8'hA5, master sends 8'h3C:
  - rx_data=8'h3C with one rx_valid pulse.
  - Master captures 8'hA5 on MISO.
  - busy falls after CS rises.
- All four CKP/CPH modes with 8'h81 in and 8'h7E out: correct words in both directions for each mode.
- Three back-to-back words 8'h01, 8'h02, 8'h03 under one CS, with tx_data changed after each rx_valid to 8'h10, 8'h20, 8'h30: three rx_valid pulses with matching rx_data, and MISO returns 8'h10, 8'h20, 8'h30.
- CS raised after 5 bits of 8'hFF:
  - frame_err pulses once, no rx_valid, rx_data keeps its previous value.
  - The next full frame 8'h55 is received correctly.
- rst asserted low after 3 bits, with CS held low through release: outputs return to reset values, and no rx_valid occurs until a new CS falling edge.
